alarm_controller: RTL and testbench

Sequencing controller for the home alarm datapath. It takes the master arm switch and four sensor switches and runs the arming state machine: exit delay, armed watch, entry delay on the door zone, and alarm. It drives the siren, indicator LEDs, a remaining-seconds countdown for the 7-segment driver, and a per-zone trip latch. It sits between the raw switch inputs and the existing display/LED logic in the top level.

---
 rtl/alarm_controller.sv | 141 ++++++++++++++
 tb/tb_alarm_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Purpose : arming sequencer for the home alarm (exit delay, armed watch, entry delay, siren).
// Latency : 3 clk edges from a raw input change to state/outputs (2 sync stages + state reg).
// Backpres: none; free-running, inputs are sampled levels and every output is a registered level.
// Ports   : clk, rst_n (async active-low); arm (master switch), sensor[3:0] (zone switches);
//           alarm (siren), led_armed, led_delay, countdown[7:0] (seconds left),
//           zone_latched[3:0] (zones tripped since last arming), state[2:0].
// Option  : define ALARM_CTRL_TIMEOUT_EN to silence the siren after ALARM_SECS and fall back
//           to ARMED; without it ALARM holds until disarmed.
module alarm_controller #(
  parameter int unsigned CLK_PER_SEC = 100_000_000,
  parameter int unsigned EXIT_SECS   = 10,
  parameter int unsigned ENTRY_SECS  = 5,
  parameter int unsigned ALARM_SECS  = 30,
  parameter logic [3:0]  ENTRY_MASK  = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic [3:0] sensor,
  output logic       alarm,
  output logic       led_armed,
  output logic       led_delay,
  output logic [7:0] countdown,
  output logic [3:0] zone_latched,
  output logic [2:0] state
);

`ifdef ALARM_CTRL_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  state_t        cur, nxt;
  logic          arm_m, arm_s;
  logic [3:0]    sen_m, sen_s;
  logic [PW-1:0] presc, presc_nxt;
  logic [7:0]    cnt_nxt;
  logic [3:0]    zl_nxt;
  logic          tick, expire, instant_trip, entry_trip;

  // Two-flop synchronizers for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_m <= 1'b0;
      arm_s <= 1'b0;
      sen_m <= '0;
      sen_s <= '0;
    end else begin
      arm_m <= arm;
      arm_s <= arm_m;
      sen_m <= sensor;
      sen_s <= sen_m;
    end
  end

  assign tick         = (presc == PW'(CLK_PER_SEC - 1));
  // The last second of a delay ends on the tick seen while the count still reads 1.
  assign expire       = tick && (countdown == 8'd1);
  assign instant_trip = |(sen_s & ~ENTRY_MASK);
  assign entry_trip   = |(sen_s & ENTRY_MASK);

  // Next-state, countdown, prescaler and latch logic.
  always_comb begin
    nxt       = cur;
    cnt_nxt   = countdown;
    presc_nxt = presc;
    zl_nxt    = zone_latched;

    if (!arm_s) begin
      nxt = S_DISARMED;
    end else begin
      case (cur)
        S_DISARMED: nxt = S_EXIT;
        S_EXIT:     if (expire) nxt = S_ARMED;
        S_ARMED: begin
          // Instant zones take priority over a simultaneous entry-zone trip.
          if (instant_trip)    nxt = S_ALARM;
          else if (entry_trip) nxt = S_ENTRY;
        end
        S_ENTRY:    if (instant_trip || expire) nxt = S_ALARM;
        S_ALARM:    if (TIMEOUT_EN && expire) nxt = S_ARMED;
        default:    nxt = S_DISARMED;
      endcase
    end

    if (nxt != cur) begin
      // Every state entry restarts the second boundary and reloads the delay.
      presc_nxt = '0;
      case (nxt)
        S_EXIT:  cnt_nxt = 8'(EXIT_SECS);
        S_ENTRY: cnt_nxt = 8'(ENTRY_SECS);
        S_ALARM: cnt_nxt = TIMEOUT_EN ? 8'(ALARM_SECS) : 8'd0;
        default: cnt_nxt = 8'd0;
      endcase
    end else begin
      presc_nxt = tick ? '0 : presc + PW'(1);
      // Count is zero outside timed states, so this only runs while a delay is live.
      if (tick && (countdown != 8'd0)) cnt_nxt = countdown - 8'd1;
    end

    if ((cur == S_ARMED) || (cur == S_ENTRY) || (cur == S_ALARM))
      zl_nxt = zone_latched | sen_s;
    if ((cur == S_DISARMED) && (nxt == S_EXIT))
      zl_nxt = '0;
  end

  // State and all outputs registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur          <= S_DISARMED;
      presc        <= '0;
      countdown    <= 8'd0;
      zone_latched <= 4'd0;
      alarm        <= 1'b0;
      led_armed    <= 1'b0;
      led_delay    <= 1'b0;
    end else begin
      cur          <= nxt;
      presc        <= presc_nxt;
      countdown    <= cnt_nxt;
      zone_latched <= zl_nxt;
      alarm        <= (nxt == S_ALARM);
      led_armed    <= (nxt == S_ARMED) || (nxt == S_ENTRY) || (nxt == S_ALARM);
      led_delay    <= (nxt == S_EXIT) || (nxt == S_ENTRY);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_alarm_controller.sv
// Purpose : bench for alarm_controller with a time-in-state reference model and directed scenarios.
// Latency : model tracks the 2-edge input delay and elapsed cycles since each state entry.
// Backpres: not applicable; inputs driven just after the falling edge, outputs sampled there.
module tb_alarm_controller;

  localparam int CPS   = 4;
  localparam int EXS   = 2;
  localparam int ENS   = 2;
  localparam int ALS   = 3;
  localparam logic [3:0] MASK = 4'b0001;
`ifdef ALARM_CTRL_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 1'b0;
  logic [3:0] sensor = 4'd0;
  logic       alarm, led_armed, led_delay;
  logic [7:0] countdown;
  logic [3:0] zone_latched;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  alarm_controller #(
    .CLK_PER_SEC(CPS), .EXIT_SECS(EXS), .ENTRY_SECS(ENS),
    .ALARM_SECS(ALS), .ENTRY_MASK(MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .sensor(sensor),
    .alarm(alarm), .led_armed(led_armed), .led_delay(led_delay),
    .countdown(countdown), .zone_latched(zone_latched), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: state, cycles spent in it, latch, and the input delay line.
  int         m_state = 0;
  int         m_el = 0;
  logic [3:0] m_zl = 4'd0;
  logic       a1 = 1'b0, a2 = 1'b0;
  logic [3:0] s1 = 4'd0, s2 = 4'd0;

  function automatic int secs_of(input int st);
    case (st)
      1:       return EXS;
      3:       return ENS;
      4:       return TMO ? ALS : 0;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int  secs;
    bit  done;
    int  ns;
    if (!rst_n) begin
      m_state = 0; m_el = 0; m_zl = 4'd0;
      a1 = 1'b0; a2 = 1'b0; s1 = 4'd0; s2 = 4'd0;
    end else begin
      secs = secs_of(m_state);
      // A delay of N seconds ends after exactly N*CPS cycles in the state.
      done = (secs != 0) && (m_el + 1 == secs * CPS);
      ns = m_state;
      if (!a2) ns = 0;
      else if (m_state == 0) ns = 1;
      else if (m_state == 1 && done) ns = 2;
      else if (m_state == 2 && (s2 & ~MASK) != 0) ns = 4;
      else if (m_state == 2 && (s2 & MASK) != 0) ns = 3;
      else if (m_state == 3 && ((s2 & ~MASK) != 0 || done)) ns = 4;
      else if (m_state == 4 && done) ns = 2;
      if (m_state >= 2) m_zl = m_zl | s2;
      if (m_state == 0 && ns == 1) m_zl = 4'd0;
      m_el = (ns != m_state) ? 0 : m_el + 1;
      m_state = ns;
      a2 = a1; a1 = arm;
      s2 = s1; s1 = sensor;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : cmp
    logic [17:0] act, exp;
    int secs, cd;
    secs = secs_of(m_state);
    cd = (secs != 0) ? secs - m_el / CPS : 0;
    exp = {m_state == 4, m_state >= 2, (m_state == 1 || m_state == 3),
           8'(cd), m_zl, 3'(m_state)};
    act = {alarm, led_armed, led_delay, countdown, zone_latched, state};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL model t=%0t: got alm/arm/dly/cd/zl/st=%b/%b/%b/%0d/%b/%0d want %b/%b/%b/%0d/%b/%0d",
               $time, act[17], act[16], act[15], act[14:7], act[6:3], act[2:0],
               exp[17], exp[16], exp[15], exp[14:7], exp[6:3], exp[2:0]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_cd", 32'(countdown), 0);
    rst_n = 1'b1;
    step(2);

    // 1: arm, sensor pulse ignored in EXIT, ARMED after 8 cycles
    arm = 1'b1;
    step(3);
    chk("exit_state", 32'(state), 1);
    chk("exit_ldly", 32'(led_delay), 1);
    chk("exit_cd2", 32'(countdown), 2);
    sensor = 4'b0100;
    step(1);
    sensor = 4'b0000;
    step(3);
    chk("exit_cd1", 32'(countdown), 1);
    chk("exit_hold", 32'(state), 1);
    step(4);
    chk("armed_state", 32'(state), 2);
    chk("armed_alarm", 32'(alarm), 0);
    chk("armed_zl", 32'(zone_latched), 0);

    // 2: entry trip then disarm before expiry
    sensor = 4'b0001;
    step(3);
    chk("entry_state", 32'(state), 3);
    chk("entry_cd", 32'(countdown), 2);
    step(2);
    arm = 1'b0;
    step(3);
    chk("entry_disarm", 32'(state), 0);
    chk("entry_zl", 32'(zone_latched), 4'b0001);
    chk("entry_noalm", 32'(alarm), 0);
    sensor = 4'b0000;

    // 3: entry delay expires into ALARM after exactly 8 cycles
    arm = 1'b1;
    step(11);
    chk("rearm_state", 32'(state), 2);
    sensor = 4'b0001;
    step(3);
    chk("entry2_state", 32'(state), 3);
    step(7);
    chk("entry2_hold", 32'(state), 3);
    step(1);
    chk("entry2_alarm", 32'(alarm), 1);
    chk("entry2_st4", 32'(state), 4);
    sensor = 4'b0000;
    arm = 1'b0;
    step(3);
    chk("alarm_disarm", 32'(alarm), 0);

    // 4: instant and entry zones together go straight to ALARM
    arm = 1'b1;
    step(3);
    chk("zl_cleared", 32'(zone_latched), 0);
    step(8);
    sensor = 4'b0101;
    step(3);
    chk("both_state", 32'(state), 4);
    chk("both_zl", 32'(zone_latched), 4'b0101);
    sensor = 4'b0000;
    arm = 1'b0;
    step(3);
    chk("both_off", 32'(alarm), 0);
    chk("both_keep", 32'(zone_latched), 4'b0101);

    // 5: disarm lands on the same edge as the entry expiry
    arm = 1'b1;
    step(11);
    sensor = 4'b0001;
    step(3);
    chk("race_entry", 32'(state), 3);
    step(5);
    arm = 1'b0;
    step(3);
    chk("race_disarm", 32'(state), 0);
    chk("race_noalm", 32'(alarm), 0);
    sensor = 4'b0000;

    // 6: sensor still high as EXIT expires
    arm = 1'b1;
    sensor = 4'b0010;
    step(11);
    chk("late_armed", 32'(state), 2);
    step(1);
    chk("late_alarm", 32'(state), 4);
    chk("late_zl", 32'(zone_latched), 4'b0010);
    sensor = 4'b0000;

    // 7: siren duration with or without the timeout
`ifdef ALARM_CTRL_TIMEOUT_EN
    step(11);
    chk("tmo_hold", 32'(state), 4);
    chk("tmo_cd", 32'(countdown), 1);
    step(1);
    chk("tmo_armed", 32'(state), 2);
    chk("tmo_off", 32'(alarm), 0);
    sensor = 4'b0010;
    step(1);
    sensor = 4'b0000;
    step(2);
    chk("tmo_retrig", 32'(state), 4);
`else
    step(100);
    chk("hold_alarm", 32'(alarm), 1);
    chk("hold_cd", 32'(countdown), 0);
`endif

    // 8: asynchronous reset in ALARM, checked before the next clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_alarm", 32'(alarm), 0);
    chk("arst_leds", 32'({led_armed, led_delay}), 0);
    chk("arst_state", 32'(state), 0);
    arm = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("post_rst", 32'(state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
